// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: state encodings, opcodes,
// bus-source and ALU operation codes, and the decode-target helper.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0000,
    S_DEC  = 4'b0001,
    S_LOAD = 4'b0010,
    S_MOV  = 4'b0011,
    S_LDPC = 4'b0100,
    S_BR   = 4'b0101,
    S_SUB0 = 4'b0110,
    S_SUB1 = 4'b0111,
    S_SUB2 = 4'b1000,
    S_ADD0 = 4'b1001,
    S_ADD1 = 4'b1010,
    S_ADD2 = 4'b1011,
    S_XOR0 = 4'b1100,
    S_XOR1 = 4'b1101,
    S_XOR2 = 4'b1110,
    S_BAD  = 4'b1111
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_LDPC = 4'b0101;
  localparam logic [3:0] OP_BR   = 4'b0110;

  localparam logic [1:0] BUS_DIN = 2'd0;
  localparam logic [1:0] BUS_REG = 2'd1;
  localparam logic [1:0] BUS_G   = 2'd2;
  localparam logic [1:0] BUS_PC  = 2'd3;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_XOR = 2'd2;

  // First execute state for an opcode; undefined opcodes fall back to IDLE.
  function automatic state_t dec_target(input logic [3:0] op);
    case (op)
      OP_LOAD: return S_LOAD;
      OP_MOV:  return S_MOV;
      OP_ADD:  return S_ADD0;
      OP_SUB:  return S_SUB0;
      OP_XOR:  return S_XOR0;
      OP_LDPC: return S_LDPC;
      OP_BR:   return S_BR;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational output decode: current state + IR + z_flag to datapath
// enables, done and illegal pulses.
module cpu_seq_decode
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16
) (
  input  state_t              state,
  input  logic [DATA_W-1:0]   ir,
  input  logic                z_flag,
  output logic [1:0]          bus_sel,
  output logic [NUM_REGS-1:0] r_out,
  output logic [NUM_REGS-1:0] r_in,
  output logic                a_in,
  output logic                g_in,
  output logic                pc_in,
  output logic [1:0]          alu_op,
  output logic                done,
  output logic                illegal
);

  localparam int REG_W = $clog2(NUM_REGS);
  localparam int LOW_W = DATA_W - 4 - 2 * REG_W;

  logic [3:0]          op;
  logic [REG_W-1:0]    rx;
  logic [REG_W-1:0]    ry;
  logic [NUM_REGS-1:0] rx_hot;
  logic [NUM_REGS-1:0] ry_hot;
  logic                low_bits_unused;

  assign op              = ir[DATA_W-1 -: 4];
  assign rx              = ir[DATA_W-5 -: REG_W];
  assign ry              = ir[DATA_W-5-REG_W -: REG_W];
  assign rx_hot          = NUM_REGS'(1) << rx;
  assign ry_hot          = NUM_REGS'(1) << ry;
  assign low_bits_unused = ^ir[LOW_W-1:0];

  always_comb begin
    bus_sel = 2'd0;
    r_out   = '0;
    r_in    = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    pc_in   = 1'b0;
    alu_op  = 2'd0;
    done    = 1'b0;
    illegal = 1'b0;
    case (state)
      S_DEC:  illegal = (dec_target(op) == S_IDLE);
      S_LOAD: begin
        bus_sel = BUS_DIN;
        r_in    = rx_hot;
        done    = 1'b1;
      end
      S_MOV: begin
        bus_sel = BUS_REG;
        r_out   = ry_hot;
        r_in    = rx_hot;
        done    = 1'b1;
      end
      S_LDPC: begin
        bus_sel = BUS_PC;
        r_in    = rx_hot;
        done    = 1'b1;
      end
      S_BR: begin
        done = 1'b1;
        // Branch taken only when G is non-zero: PC <= rx.
        if (!z_flag) begin
          bus_sel = BUS_REG;
          r_out   = rx_hot;
          pc_in   = 1'b1;
        end
      end
      S_ADD0, S_SUB0, S_XOR0: begin
        r_out = rx_hot;
        a_in  = 1'b1;
      end
      S_ADD1, S_SUB1, S_XOR1: begin
        r_out  = ry_hot;
        g_in   = 1'b1;
        alu_op = (state == S_ADD1) ? ALU_ADD :
                 (state == S_SUB1) ? ALU_SUB : ALU_XOR;
      end
      S_ADD2, S_SUB2, S_XOR2: begin
        bus_sel = BUS_G;
        r_in    = rx_hot;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control unit: state register, IR and next-state logic.
// Optional one-entry prefetch buffer enabled by CPU_SEQ_PREFETCH_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [DATA_W-1:0]   instr,
  output logic                instr_ready,
  input  logic                z_flag,
  output logic [1:0]          bus_sel,
  output logic [NUM_REGS-1:0] r_out,
  output logic [NUM_REGS-1:0] r_in,
  output logic                a_in,
  output logic                g_in,
  output logic                pc_in,
  output logic [1:0]          alu_op,
  output logic                done,
  output logic                illegal
);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] ir_reg, ir_next;
  logic              accept;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_word;

  assign accept = instr_valid & instr_ready;

`ifdef CPU_SEQ_PREFETCH_EN
  logic              buf_valid_reg;
  logic [DATA_W-1:0] buf_reg;
  logic              drain;

  assign buf_valid   = buf_valid_reg;
  assign buf_word    = buf_reg;
  assign instr_ready = !reset && !buf_valid_reg;
  // The buffer hands its word to IR from IDLE or on any instruction end.
  assign drain = buf_valid_reg && ((state_reg == S_IDLE) || done || illegal);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid_reg <= 1'b0;
      buf_reg       <= '0;
    end else if (accept && state_reg != S_IDLE) begin
      buf_valid_reg <= 1'b1;
      buf_reg       <= instr;
    end else if (drain) begin
      buf_valid_reg <= 1'b0;
    end
  end
`else
  assign buf_valid   = 1'b0;
  assign buf_word    = '0;
  assign instr_ready = !reset && (state_reg == S_IDLE);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    case (state_reg)
      S_IDLE: begin
        if (buf_valid) begin
          state_next = S_DEC;
          ir_next    = buf_word;
        end else if (accept) begin
          state_next = S_DEC;
          ir_next    = instr;
        end
      end
      S_DEC:  state_next = dec_target(ir_reg[DATA_W-1 -: 4]);
      S_ADD0: state_next = S_ADD1;
      S_ADD1: state_next = S_ADD2;
      S_SUB0: state_next = S_SUB1;
      S_SUB1: state_next = S_SUB2;
      S_XOR0: state_next = S_XOR1;
      S_XOR1: state_next = S_XOR2;
      default: state_next = S_IDLE;
    endcase
    // A buffered instruction skips IDLE and goes straight to decode.
    if ((done || illegal) && buf_valid) begin
      state_next = S_DEC;
      ir_next    = buf_word;
    end
  end

  cpu_seq_decode #(
    .NUM_REGS(NUM_REGS),
    .DATA_W  (DATA_W)
  ) u_decode (
    .state  (state_reg),
    .ir     (ir_reg),
    .z_flag (z_flag),
    .bus_sel(bus_sel),
    .r_out  (r_out),
    .r_in   (r_in),
    .a_in   (a_in),
    .g_in   (g_in),
    .pc_in  (pc_in),
    .alu_op (alu_op),
    .done   (done),
    .illegal(illegal)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction-step reference model,
// directed literal scenarios, then randomized traffic with random resets.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        z_flag;
  logic [1:0]  bus_sel;
  logic [7:0]  r_out;
  logic [7:0]  r_in;
  logic        a_in, g_in, pc_in;
  logic [1:0]  alu_op;
  logic        done, illegal;

  always #5 clk = ~clk;

  cpu_sequencer #(.NUM_REGS(8), .DATA_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .z_flag     (z_flag),
    .bus_sel    (bus_sel),
    .r_out      (r_out),
    .r_in       (r_in),
    .a_in       (a_in),
    .g_in       (g_in),
    .pc_in      (pc_in),
    .alu_op     (alu_op),
    .done       (done),
    .illegal    (illegal)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: instruction in flight and how many cycles since it entered decode.
  bit          m_busy = 0;
  logic [15:0] m_cur  = '0;
  int          m_step = 0;
  bit          m_bv   = 0;
  logic [15:0] m_buf  = '0;

  // Snapshot of DUT outputs at the last compare point.
  logic       s_ready, s_a, s_g, s_pc, s_done, s_ill;
  logic [1:0] s_bus, s_alu;
  logic [7:0] s_rout, s_rin;

  // Cycles an instruction occupies from decode to its last state.
  function automatic int op_len(input logic [3:0] op);
    if (op >= 4'd7) return 1;
    if (op >= 4'd2 && op <= 4'd4) return 4;
    return 2;
  endfunction

  function automatic logic [25:0] model_out();
    logic       rdy, a, g, p, d, il;
    logic [1:0] bs, al;
    logic [7:0] ro, ri, xh, yh;
    logic [3:0] op;
    op = m_cur[15:12];
    xh = 8'd1 << m_cur[11:9];
    yh = 8'd1 << m_cur[8:6];
    {a, g, p, d, il} = '0;
    bs = 2'd0; al = 2'd0; ro = '0; ri = '0;
`ifdef CPU_SEQ_PREFETCH_EN
    rdy = !m_bv;
`else
    rdy = !m_busy;
`endif
    if (reset) rdy = 1'b0;
    if (!reset && m_busy) begin
      if (m_step == 0) begin
        il = (op >= 4'd7);
      end else if (op >= 4'd2 && op <= 4'd4) begin
        case (m_step)
          1: begin ro = xh; a = 1'b1; end
          2: begin ro = yh; g = 1'b1; al = (op == 4'd2) ? 2'd0 : (op == 4'd3) ? 2'd1 : 2'd2; end
          default: begin bs = 2'd2; ri = xh; d = 1'b1; end
        endcase
      end else begin
        d = 1'b1;
        case (op)
          4'd0: begin bs = 2'd0; ri = xh; end
          4'd1: begin bs = 2'd1; ro = yh; ri = xh; end
          4'd5: begin bs = 2'd3; ri = xh; end
          default: if (!z_flag) begin bs = 2'd1; ro = xh; p = 1'b1; end
        endcase
      end
    end
    return {rdy, bs, ro, ri, a, g, p, al, d, il};
  endfunction

  task automatic model_edge(input bit acc, input logic [15:0] word);
    if (reset) begin
      m_busy = 0; m_step = 0; m_bv = 0; m_cur = '0;
    end else if (!m_busy) begin
      if (m_bv) begin
        m_cur = m_buf; m_busy = 1; m_step = 0; m_bv = 0;
      end else if (acc) begin
        m_cur = word; m_busy = 1; m_step = 0;
      end
    end else begin
      m_step++;
      if (m_step == op_len(m_cur[15:12])) begin
        if (m_bv) begin
          m_cur = m_buf; m_step = 0; m_bv = 0;
        end else begin
          m_busy = 0;
        end
      end
      if (acc) begin
        m_buf = word; m_bv = 1;
      end
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: compare at negedge against the model, advance model at posedge.
  task automatic step_cycle();
    logic [25:0] exp, act;
    bit          acc;
    logic [15:0] w;
    @(negedge clk);
    exp = model_out();
    act = {instr_ready, bus_sel, r_out, r_in, a_in, g_in, pc_in, alu_op, done, illegal};
    {s_ready, s_bus, s_rout, s_rin, s_a, s_g, s_pc, s_alu, s_done, s_ill} = act;
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act, exp);
    acc = instr_valid && exp[25];
    w   = instr;
    @(posedge clk);
    model_edge(acc, w);
    cyc++;
    #1;
  endtask

  task automatic issue(input logic [15:0] word);
    instr_valid = 1'b1; instr = word;
    step_cycle();
    lit("accept_ready", s_ready, 1);
    instr_valid = 1'b0; instr = ~word;
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; z_flag = 1'b0;
    repeat (3) step_cycle();
    lit("reset_ready", s_ready, 0);
    lit("reset_done", s_done, 0);
    reset = 1'b0;

    // LOAD r3
    issue(16'h0600);
    step_cycle();
    lit("load_c1_done", s_done, 0);
    step_cycle();
    lit("load_c2_bus", s_bus, 0);
    lit("load_c2_rin", s_rin, 8'h08);
    lit("load_c2_done", s_done, 1);
    step_cycle();
    lit("load_c3_ready", s_ready, 1);

    // ADD r1,r2
    issue(16'h2280);
    step_cycle();
    step_cycle();
    lit("add_c2_rout", s_rout, 8'h02);
    lit("add_c2_ain", s_a, 1);
    step_cycle();
    lit("add_c3_rout", s_rout, 8'h04);
    lit("add_c3_gin", s_g, 1);
    lit("add_c3_alu", s_alu, 0);
    step_cycle();
    lit("add_c4_bus", s_bus, 2);
    lit("add_c4_rin", s_rin, 8'h02);
    lit("add_c4_done", s_done, 1);

    // BR r5, taken then not taken
    for (int zb = 0; zb < 2; zb++) begin
      z_flag = 1'b0;
      issue(16'h6A00);
      step_cycle();
      z_flag = (zb == 1);
      step_cycle();
      lit("br_pc_in", s_pc, (zb == 0) ? 1 : 0);
      lit("br_rout", s_rout, (zb == 0) ? 8'h20 : 8'h00);
      lit("br_done", s_done, 1);
    end

    // Undefined opcode
    issue(16'hF000);
    step_cycle();
    lit("ill_c1_illegal", s_ill, 1);
    lit("ill_c1_done", s_done, 0);
    step_cycle();
    lit("ill_c2_ready", s_ready, 1);
    lit("ill_c2_done", s_done, 0);

    // Reset during ADD1
    issue(16'h2280);
    step_cycle();
    step_cycle();
    reset = 1'b1;
    #1;
    lit("rst_mid_rout", r_out, 0);
    lit("rst_mid_gin", g_in, 0);
    lit("rst_mid_ready", instr_ready, 0);
    step_cycle();
    reset = 1'b0;
    step_cycle();
    lit("rst_post_ready", s_ready, 1);
    lit("rst_post_done", s_done, 0);
    step_cycle();
    lit("rst_post2_done", s_done, 0);

`ifdef CPU_SEQ_PREFETCH_EN
    // SUB r1,r2 then MOV r5,r1 offered during SUB0
    issue(16'h3280);
    step_cycle();
    instr_valid = 1'b1; instr = 16'h1A40;
    step_cycle();
    lit("pf_mov_accept", s_ready, 1);
    instr_valid = 1'b0;
    step_cycle();
    step_cycle();
    lit("pf_sub_done", s_done, 1);
    step_cycle();
    lit("pf_dec_done", s_done, 0);
    step_cycle();
    lit("pf_mov_done", s_done, 1);
    lit("pf_mov_rin", s_rin, 8'h20);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      instr_valid = ($urandom_range(0, 9) < 6);
      instr       = {op, 12'($urandom)};
      z_flag      = $urandom_range(0, 1) == 1;
      if (reset) reset = 1'b0;
      else reset = ($urandom_range(0, 199) == 0);
      step_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
